packed_array_reader: RTL
========================

Name: packed_array_reader

Overview:
- Read-side counterpart to the team's packed 3D array register writer.
- Holds a 2x2x8 packed array image, loaded from the writer's full-vector output.
- Serves read requests at five granularities over a valid/ready request and response handshake: bit, part-select nibble, element, slice, whole vector.
- Also serves a stream mode that emits every element in sequence, one per response beat.

Parameters:
- ELEM_W, 8, bits per innermost element.
- DIM0, 2, elements per slice (middle index j).
- DIM1, 2, slices in the array (outer index i).
- Derived: TOT_W=DIM1*DIM0*ELEM_W (32); SL_W=DIM0*ELEM_W (16); IW=max(1,$clog2(DIM1)); JW=max(1,$clog2(DIM0)); KW=$clog2(ELEM_W).

Ports:
- Interface (already decided): reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  capture load_data into the array on this edge.
- load_data  in  TOT_W  full packed vector from the writer; element [i][j] = bits [(i*DIM0+j)*ELEM_W +: ELEM_W].
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_mode  in  3  0 bit, 1 nibble, 2 element, 3 slice, 4 whole, 5 stream, 6-7 illegal.
- req_i  in  IW  slice index.
- req_j  in  JW  element index.
- req_k  in  KW  bit index (mode 0); req_k[KW-1] selects upper nibble (mode 1).
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response beat consumed when rsp_valid&&rsp_ready.
- rsp_data  out  TOT_W  zero-extended read data.
- rsp_last  out  1  final beat of a response (always 1 except non-final stream beats).
- rsp_err  out  1  illegal mode or out-of-range index.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: array=0; FSM=IDLE; rsp_valid=0; rsp_data=0; rsp_last=0; rsp_err=0; req_ready=1; busy=0.
- Reset asserted mid-stream or mid-response aborts immediately; no further beats are issued.
- Load: on load_valid, the array takes load_data at the clock edge. Load has priority over nothing, since it is the only writer.
- Load/request same edge: a request accepted on the same edge as a load sees the pre-load array value.
- FSM states: IDLE, RESP, STREAM.
- req_ready = (state==IDLE).
- IDLE, on accept with mode 0-4 or illegal: compute rsp_data from the array, register it, rsp_valid=1, rsp_last=1, go to RESP. Latency is 1 cycle from accept to rsp_valid.
- Mode 0: array[i][j][k] at bit 0.
- Mode 1: 4-bit nibble [i][j][k[KW-1]*4 +: 4].
- Mode 2: element [i][j].
- Mode 3: slice [i] (SL_W bits).
- Mode 4: whole vector.
- Error cases: modes 6-7, req_i>=DIM1, or req_j>=DIM0 (non-power-of-2 dims) give rsp_err=1 and rsp_data=0.
- RESP: outputs are held stable while rsp_valid && !rsp_ready. On the handshake, rsp_valid=0 and the FSM returns to IDLE. req_ready rises the cycle after the handshake.
- IDLE, on accept with mode 5: snapshot the whole array into a shadow register, set the element counter to 0, go to STREAM.
  - Beats emit element index 0..DIM1*DIM0-1, LSB element first ([0][0],[0][1],[1][0],[1][1]).
  - Each beat is registered; the counter advances only on a handshake.
  - rsp_last=1 on the final beat; after its handshake, return to IDLE.
  - A load during STREAM updates the array but not the shadow, so stream data is unaffected.
- No pipelining of requests: there is at most one outstanding request.
- rsp_data upper bits beyond the selected width are always 0.

Optional Feature:
- Macro: PACKED_RD_PARITY_EN.
- When defined: adds output rsp_parity (1 bit) = even parity (XOR reduction) of rsp_data. It is registered alongside rsp_data, reset value 0, and held with rsp_data under backpressure.
- When undefined: the port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then load 32'h01234567; read mode 4 -> rsp_data=32'h01234567, rsp_err=0, rsp_last=1, one cycle after accept.
- Same array:
  - mode 2 i=1 j=0 -> 32'h23;
  - mode 3 i=0 -> 32'h4567;
  - mode 1 i=0 j=0 k=4 -> 32'h6;
  - mode 0 i=0 j=0 k=0 -> 32'h1.
- Mode 5 with rsp_ready low for 3 cycles on beat 1 -> beats 32'h67, 32'h45 (held stable), 32'h23, 32'h01; rsp_last only on 32'h01; req_ready=0 throughout.
- Load 32'hFFFFFFFF during the second stream beat -> remaining beats still 32'h23, 32'h01; a subsequent mode 4 read -> 32'hFFFFFFFF.
- Request mode 7 -> rsp_err=1, rsp_data=0; request with load_valid on the same edge -> returns the old value.
- Assert rst_n low mid-stream -> rsp_valid=0, busy=0, array=0 next read; with PACKED_RD_PARITY_EN, mode 4 of 32'h00000007 -> rsp_parity=1.

Source files
------------

// File: rtl/packed_array_reader.sv
// Read port for the 2x2x8 packed array image: bit/nibble/element/slice/whole reads plus element streaming.
// Optional rsp_parity output when PACKED_RD_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// RESP   | single-beat response held until rsp_ready
// STREAM | emitting shadow elements one per handshake
module packed_array_reader #(
  parameter int ELEM_W = 8,
  parameter int DIM0   = 2,
  parameter int DIM1   = 2,
  localparam int TOT_W = DIM1 * DIM0 * ELEM_W,
  localparam int SL_W  = DIM0 * ELEM_W,
  localparam int IW    = (DIM1 > 1) ? $clog2(DIM1) : 1,
  localparam int JW    = (DIM0 > 1) ? $clog2(DIM0) : 1,
  localparam int KW    = $clog2(ELEM_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [TOT_W-1:0] load_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_mode,
  input  logic [IW-1:0]    req_i,
  input  logic [JW-1:0]    req_j,
  input  logic [KW-1:0]    req_k,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TOT_W-1:0] rsp_data,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             busy
`ifdef PACKED_RD_PARITY_EN
  ,
  output logic             rsp_parity
`endif
);

  localparam int NEL = DIM1 * DIM0;
  localparam int CW  = (NEL > 1) ? $clog2(NEL) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NEL - 1);

  typedef enum logic [1:0] {IDLE, RESP, STREAM} state_t;

  state_t           state, state_d;
  logic [TOT_W-1:0] arr, shadow, shadow_d;
  logic [CW-1:0]    cnt, cnt_d, cnt_nxt;
  logic [TOT_W-1:0] data_d, rd_data, stream_data;
  logic             valid_d, last_d, err_d, rd_err, in_range;
  logic [ELEM_W-1:0] elem;
  logic [SL_W-1:0]  slice;
  int               elem_idx, nib_base;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cnt_nxt   = cnt + CW'(1);

  // Single-beat read mux, evaluated against the pre-load array.
  always_comb begin
    rd_data  = '0;
    rd_err   = 1'b0;
    elem_idx = int'(req_i) * DIM0 + int'(req_j);
    in_range = (int'(req_i) < DIM1) && (int'(req_j) < DIM0);
    nib_base = req_k[KW-1] ? 4 : 0;
    elem     = in_range ? arr[elem_idx*ELEM_W +: ELEM_W] : '0;
    slice    = (int'(req_i) < DIM1) ? arr[int'(req_i)*SL_W +: SL_W] : '0;
    case (req_mode)
      3'd0: rd_data[0] = elem[req_k];
      3'd1: rd_data[3:0] = elem[nib_base +: 4];
      3'd2: rd_data[ELEM_W-1:0] = elem;
      3'd3: rd_data[SL_W-1:0] = slice;
      3'd4: rd_data = arr;
      default: rd_err = 1'b1;
    endcase
    if (req_mode <= 3'd3 && !in_range) rd_err = 1'b1;
    if (rd_err) rd_data = '0;
  end

  always_comb begin
    stream_data = '0;
    stream_data[ELEM_W-1:0] = shadow[int'(cnt_nxt)*ELEM_W +: ELEM_W];
  end

  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    cnt_d    = cnt;
    data_d   = rsp_data;
    valid_d  = rsp_valid;
    last_d   = rsp_last;
    err_d    = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          valid_d = 1'b1;
          if (req_mode == 3'd5) begin
            shadow_d = arr;
            cnt_d    = '0;
            data_d   = '0;
            data_d[ELEM_W-1:0] = arr[ELEM_W-1:0];
            last_d   = (NEL == 1);
            err_d    = 1'b0;
            state_d  = STREAM;
          end else begin
            data_d  = rd_data;
            err_d   = rd_err;
            last_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_nxt;
            data_d = stream_data;
            last_d = (cnt_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arr       <= '0;
      shadow    <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      shadow    <= shadow_d;
      cnt       <= cnt_d;
      rsp_data  <= data_d;
      rsp_valid <= valid_d;
      rsp_last  <= last_d;
      rsp_err   <= err_d;
      if (load_valid) arr <= load_data;
    end
  end

`ifdef PACKED_RD_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_parity <= 1'b0;
    else        rsp_parity <= ^data_d;
  end
`endif

endmodule
